// File: rtl/kbd_io_pkg.sv
// Shared definitions for the keyboard peripheral: register map, bit positions, FIFO entry layout.
package kbd_io_pkg;

    localparam int ENTRY_W = 10;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_STAT  = 2'd1;
    localparam logic [1:0] REG_CTRL  = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    localparam int STAT_NEMPTY = 0;
    localparam int STAT_OVF    = 1;
    localparam int STAT_IRQEN  = 2;
    localparam int CTRL_IRQEN  = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } kbd_entry_t;

    // DATA register image of a valid head entry.
    function automatic logic [15:0] data_word(input kbd_entry_t e);
        return {1'b1, 5'b0, e};
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO for key events; push while full is accepted only when a pop happens the same cycle.
module kbd_fifo
    import kbd_io_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  kbd_entry_t            din,
    output kbd_entry_t            head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    kbd_entry_t            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kbd_io.sv
// 68000 bus peripheral: captures ps2_key events into a FIFO, exposes word registers, drives IPL.
module kbd_io
    import kbd_io_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [2:0] IRQ_LEVEL  = 3'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        sel,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic [1:0]  cpu_a,
    input  logic [15:0] cpu_dout,
    output logic [15:0] dout,
    output logic [2:0]  ipl_n
);

    logic                last_tog;
    logic                ev_valid;
    kbd_entry_t          ev_data;
    kbd_entry_t          head;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                empty;
    logic                cyc;
    logic                cyc_d;
    logic                rd_data_cyc;
    logic                wr_done;
    logic                wr_fire;
    logic                pop;
    logic                flush;
    logic                ovf_set;
    logic                ovf_clr;
    logic                overflow;
    logic                irq_en;
    logic [15:0]         rd_word;

    // A bus cycle is sel with AS low. Reads are served from dout one clk later and have no
    // side effect except the DATA pop, taken once at the end of AS. A write acts once, on the
    // first clk of the cycle with LDS low; UDS-only writes are ignored.
    assign cyc     = sel & ~cpu_as_n;
    assign wr_fire = cyc & ~cpu_rw & ~cpu_lds_n & ~wr_done;
    assign pop     = cyc_d & ~cyc & rd_data_cyc;
    assign flush   = wr_fire & (cpu_a == REG_CTRL) & cpu_dout[CTRL_FLUSH];
    assign ovf_clr = wr_fire & (cpu_a == REG_STAT) & cpu_dout[STAT_OVF];
    assign ovf_set = ev_valid & full & ~(pop & ~empty) & ~flush;

    kbd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (ev_valid),
        .pop     (pop),
        .flush   (flush),
        .din     (ev_data),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        rd_word = '0;
        case (cpu_a)
            REG_DATA:  rd_word = empty ? 16'h0000 : data_word(head);
            REG_STAT:  rd_word = {13'b0, irq_en, overflow, ~empty};
            REG_CTRL:  rd_word = {15'b0, irq_en};
            default:   rd_word = 16'(count);
        endcase
    end

    // last_tog follows the toggle bit even in reset so no phantom event appears on release.
    always_ff @(posedge clk) begin
        last_tog <= ps2_key[10];
        if (!reset_n) begin
            ev_valid    <= 1'b0;
            ev_data     <= '0;
            cyc_d       <= 1'b0;
            rd_data_cyc <= 1'b0;
            wr_done     <= 1'b0;
            overflow    <= 1'b0;
            irq_en      <= 1'b0;
            dout        <= '0;
            ipl_n       <= 3'b111;
        end else begin
            ev_valid    <= (ps2_key[10] != last_tog);
            ev_data     <= ps2_key[9:0];
            cyc_d       <= cyc;
            rd_data_cyc <= cyc & (rd_data_cyc | (cpu_rw & (cpu_a == REG_DATA)));
            wr_done     <= cyc & (wr_done | wr_fire);
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (wr_fire && cpu_a == REG_CTRL) irq_en <= cpu_dout[CTRL_IRQEN];
            dout  <= cyc ? rd_word : 16'h0000;
            ipl_n <= (irq_en & ~empty) ? ~IRQ_LEVEL : 3'b111;
        end
    end

endmodule
